mmc3_scanline_irq: RTL and testbench
====================================

MMC3_SCANLINE_IRQ -- requirements
Module: mmc3_scanline_irq

Interface
REQ-001 SHALL have parameter A12_FILTER, default 3: M2 cycles PPU A12 must stay low before a rising edge counts as a scanline clock (range 1-15).
REQ-002 SHALL have parameter NEW_IRQ_MODE, default 1: 1 selects new-revision zero behaviour, 0 selects old-revision zero behaviour.
REQ-003 SHALL have port m2  input  1  CPU M2; the single clock, and all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port reg_we  input  1  one-cycle write strobe from the mapper register decoder.
REQ-006 SHALL have port reg_sel  input  2  register select: 0 latch ($C000), 1 reload ($C001), 2 disable ($E000), 3 enable ($E001).
REQ-007 SHALL have port reg_data  input  8  write data; used only by latch writes.
REQ-008 SHALL have port ppu_a12  input  1  raw PPU address bit 12, asynchronous to m2.
REQ-009 SHALL have port irq_n  output  1  active-low IRQ request to the top-level irq pin.
REQ-010 SHALL have port counter  output  8  current counter value, for debug.

Function
REQ-011 SHALL pass ppu_a12 through a 2-flop synchronizer before any use.
REQ-012 SHALL keep a 4-bit low-time counter that increments while synchronized A12 is 0, saturates at A12_FILTER, and clears when A12 is 1.
REQ-013 SHALL produce a scanline clock for exactly one cycle when synchronized A12 goes 0->1 and the low-time counter equals A12_FILTER.
REQ-014 SHALL, on a latch write, load latch <= reg_data, with no other effect.
REQ-015 SHALL, on a reload write, set reload_flag <= 1 and clear counter <= 0.
REQ-016 SHALL, on a disable write, clear enabled <= 0 and pending <= 0.
REQ-017 SHALL, on an enable write, set enabled <= 1 and leave pending unchanged.
REQ-018 SHALL, on a scanline clock with counter==0 or reload_flag==1, load counter <= latch and clear reload_flag; otherwise it decrements counter by 1 (8-bit, no wrap possible).
REQ-019 SHALL, when NEW_IRQ_MODE=1, set pending when counter is 0 after a scanline clock and enabled==1.
REQ-020 SHALL, when NEW_IRQ_MODE=0, set pending only when counter is 0 after a clock and either the pre-clock counter was nonzero or reload_flag was 1, with enabled==1.
REQ-021 SHALL drive irq_n = ~pending combinationally from the register, so assertion appears on the cycle after the scanline clock.
REQ-022 SHALL keep pending set until a disable write or reset; further clocks do not clear it.
REQ-023 SHALL, when a write and a scanline clock occur in the same cycle, use pre-write latch and enabled values for the clock step.
REQ-024 SHALL, when a reload write and a clock occur in the same cycle, end with counter=0 and reload_flag=1.
REQ-025 SHALL, when a disable write and pending assertion occur in the same cycle, end with pending=0.
REQ-026 SHALL ignore reg_sel and reg_data when reg_we=0.

Reset
REQ-027 SHALL, while reset=1 at a rising m2 edge, clear latch, counter, reload_flag, enabled, pending, the synchronizer and the low-time counter to 0, giving irq_n=1 and counter=0.
REQ-028 SHALL give reset priority over any simultaneous write or scanline clock.
REQ-029 SHALL, when reset is asserted mid-count, lose any partially accumulated low-time, so the first A12 rise after reset never counts unless preceded by A12_FILTER low cycles.

Structure
REQ-030 SHALL take the reg_sel encodings (REG_LATCH, REG_RELOAD, REG_DISABLE, REG_ENABLE) from the shared coolgirl_pkg package, which the mapper register decoder also uses.
REQ-031 SHALL place the synchronizer, low-time counter and edge detect in one sub-module, a12_edge_filter, whose single output is the scanline clock pulse.

Verification
REQ-032 SHALL cover: latch=3, reload write, enable; 4 filtered A12 rises (each after 5 low cycles) -> counter 3,2,1,0; irq_n=0 one cycle after the 4th rise.
REQ-033 SHALL cover: A12 pulses with only 2 low cycles between them (A12_FILTER=3) -> no scanline clocks; counter unchanged.
REQ-034 SHALL cover: pending set, then disable write -> irq_n=1 next cycle; a later enable write without a new zero -> irq_n stays 1.
REQ-035 SHALL cover: latch=0 with counter already 0, one clock -> NEW_IRQ_MODE=1 asserts irq_n=0; NEW_IRQ_MODE=0 keeps irq_n=1 unless reload_flag was set.
REQ-036 SHALL cover: reload write coincident with a scanline clock -> counter=0, reload_flag=1; the next clock loads the latch value.
REQ-037 SHALL cover: reset asserted with counter=5 and pending=1 -> next edge gives counter=0, irq_n=1, enabled=0.

Source files
------------

// File: rtl/coolgirl_pkg.sv
// Shared definitions for the CoolGirl mapper: register-select encodings used by
// the register decoder and by the MMC3-style scanline IRQ block.
package coolgirl_pkg;

  typedef enum logic [1:0] {
    REG_LATCH   = 2'd0,
    REG_RELOAD  = 2'd1,
    REG_DISABLE = 2'd2,
    REG_ENABLE  = 2'd3
  } reg_sel_e;

  localparam int A12_LOWCNT_W = 4;

endpackage

// File: rtl/mmc3_scanline_irq_a12_edge_filter.sv
// Synchronizes raw PPU A12 into the M2 domain and emits a one-cycle scanline
// pulse on a rising edge that follows at least A12_FILTER low cycles.
module a12_edge_filter
  import coolgirl_pkg::*;
#(
  parameter int A12_FILTER = 3
) (
  input  logic m2_i,
  input  logic reset_i,
  input  logic ppu_a12_i,
  output logic scanline_o
);

  logic                    a12Meta_q, a12Sync_q;
  logic [A12_LOWCNT_W-1:0] lowCnt_q, lowCnt_d;

  always_comb begin
    lowCnt_d = lowCnt_q;
    if (a12Sync_q) begin
      lowCnt_d = '0;
    end else if (lowCnt_q != A12_LOWCNT_W'(A12_FILTER)) begin
      lowCnt_d = lowCnt_q + 1'b1;
    end
  end

  always_ff @(posedge m2_i) begin
    if (reset_i) begin
      a12Meta_q <= 1'b0;
      a12Sync_q <= 1'b0;
      lowCnt_q  <= '0;
    end else begin
      a12Meta_q <= ppu_a12_i;
      a12Sync_q <= a12Meta_q;
      lowCnt_q  <= lowCnt_d;
    end
  end

  // A saturated low count implies the previous synchronized sample was 0, so
  // a high sample here is exactly a qualified 0->1 edge; it lasts one cycle
  // because the count clears on the next edge.
  assign scanline_o = a12Sync_q && (lowCnt_q == A12_LOWCNT_W'(A12_FILTER));

endmodule

// File: rtl/mmc3_scanline_irq.sv
// MMC3-compatible scanline counter and IRQ generator clocked by CPU M2,
// counting filtered PPU A12 rising edges.
module mmc3_scanline_irq
  import coolgirl_pkg::*;
#(
  parameter int A12_FILTER   = 3,
  parameter int NEW_IRQ_MODE = 1
) (
  input  logic       m2,
  input  logic       reset,
  input  logic       reg_we,
  input  logic [1:0] reg_sel,
  input  logic [7:0] reg_data,
  input  logic       ppu_a12,
  output logic       irq_n,
  output logic [7:0] counter
);

  logic       scanline;
  logic [7:0] latch_q, latch_d;
  logic [7:0] counter_q, counter_d;
  logic       reload_q, reload_d;
  logic       enabled_q, enabled_d;
  logic       pending_q, pending_d;
  logic       zeroHit;

  a12_edge_filter #(.A12_FILTER(A12_FILTER)) u_filter (
    .m2_i       (m2),
    .reset_i    (reset),
    .ppu_a12_i  (ppu_a12),
    .scanline_o (scanline)
  );

  // Clock step first (with pre-write latch/enabled), then register writes
  // override it, so a same-cycle reload or disable wins.
  always_comb begin
    latch_d   = latch_q;
    counter_d = counter_q;
    reload_d  = reload_q;
    enabled_d = enabled_q;
    pending_d = pending_q;
    zeroHit   = 1'b0;

    if (scanline) begin
      if (counter_q == 8'd0 || reload_q) begin
        counter_d = latch_q;
        reload_d  = 1'b0;
      end else begin
        counter_d = counter_q - 8'd1;
      end
      if (NEW_IRQ_MODE != 0) begin
        zeroHit = (counter_d == 8'd0);
      end else begin
        zeroHit = (counter_d == 8'd0) && (counter_q != 8'd0 || reload_q);
      end
      if (zeroHit && enabled_q) begin
        pending_d = 1'b1;
      end
    end

    if (reg_we) begin
      case (reg_sel_e'(reg_sel))
        REG_LATCH:   latch_d = reg_data;
        REG_RELOAD: begin
          reload_d  = 1'b1;
          counter_d = 8'd0;
        end
        REG_DISABLE: begin
          enabled_d = 1'b0;
          pending_d = 1'b0;
        end
        REG_ENABLE:  enabled_d = 1'b1;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge m2) begin
    if (reset) begin
      latch_q   <= 8'd0;
      counter_q <= 8'd0;
      reload_q  <= 1'b0;
      enabled_q <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      latch_q   <= latch_d;
      counter_q <= counter_d;
      reload_q  <= reload_d;
      enabled_q <= enabled_d;
      pending_q <= pending_d;
    end
  end

  assign irq_n   = ~pending_q;
  assign counter = counter_q;

endmodule

// File: tb/tb_mmc3_scanline_irq.sv
// Self-checking bench: new- and old-revision instances share stimulus and are
// compared every cycle against a history-based reference model.
module tb_mmc3_scanline_irq;

  localparam int FILTER = 3;

  logic       m2;
  logic       reset;
  logic       reg_we;
  logic [1:0] reg_sel;
  logic [7:0] reg_data;
  logic       ppu_a12;
  logic       irqNNew, irqNOld;
  logic [7:0] counterNew, counterOld;

  int testCount = 0;
  int failCount = 0;

  // Reference state: 2 marks a reset barrier in the raw A12 sample history.
  int       a12Hist[$];
  bit [7:0] mLatch, mCnt;
  bit       mReload, mEn, mPendNew, mPendOld;
  bit       a12Level;

  mmc3_scanline_irq #(.A12_FILTER(FILTER), .NEW_IRQ_MODE(1)) dutNew (
    .m2(m2), .reset(reset), .reg_we(reg_we), .reg_sel(reg_sel),
    .reg_data(reg_data), .ppu_a12(ppu_a12), .irq_n(irqNNew), .counter(counterNew)
  );

  mmc3_scanline_irq #(.A12_FILTER(FILTER), .NEW_IRQ_MODE(0)) dutOld (
    .m2(m2), .reset(reset), .reg_we(reg_we), .reg_sel(reg_sel),
    .reg_data(reg_data), .ppu_a12(ppu_a12), .irq_n(irqNOld), .counter(counterOld)
  );

  initial begin
    m2 = 1'b0;
    forever #5 m2 = ~m2;
  end

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, " counterNew"}, counterNew, mCnt);
    check({tag, " counterOld"}, counterOld, mCnt);
    check({tag, " irqNNew"}, {7'd0, irqNNew}, {7'd0, ~mPendNew});
    check({tag, " irqNOld"}, {7'd0, irqNOld}, {7'd0, ~mPendOld});
  endtask

  // A scanline clock is due at this edge when the sample taken two edges ago
  // is high and is preceded by at least FILTER low samples.
  function automatic bit modelPulse();
    int run = 0;
    int n = a12Hist.size();
    if (n < 2 || a12Hist[n-2] != 1) return 1'b0;
    for (int i = n - 3; i >= 0; i--) begin
      if (a12Hist[i] != 0) break;
      run++;
    end
    return run >= FILTER;
  endfunction

  task automatic applyStimulus(input bit rst, input bit we, input logic [1:0] sel,
                               input logic [7:0] data, input bit a12, input string tag);
    bit [7:0] cN;
    bit       rN, pN, pO, pulse;
    reset = rst; reg_we = we; reg_sel = sel; reg_data = data; ppu_a12 = a12;
    pulse = modelPulse();
    if (rst) begin
      mLatch = 0; mCnt = 0; mReload = 0; mEn = 0; mPendNew = 0; mPendOld = 0;
      a12Hist.delete();
      a12Hist.push_back(2); a12Hist.push_back(0); a12Hist.push_back(0);
    end else begin
      cN = mCnt; rN = mReload; pN = mPendNew; pO = mPendOld;
      if (pulse) begin
        if (mCnt == 0 || mReload) begin cN = mLatch; rN = 0; end
        else cN = mCnt - 8'd1;
        if (cN == 0 && mEn) begin
          pN = 1;
          if (mCnt != 0 || mReload) pO = 1;
        end
      end
      if (we) begin
        case (sel)
          2'd0: mLatch = data;
          2'd1: begin rN = 1; cN = 0; end
          2'd2: begin mEn = 0; pN = 0; pO = 0; end
          default: mEn = 1;
        endcase
      end
      mCnt = cN; mReload = rN; mPendNew = pN; mPendOld = pO;
      a12Hist.push_back(int'(a12));
      if (a12Hist.size() > 40) void'(a12Hist.pop_front());
    end
    @(posedge m2);
    @(negedge m2);
    checkOutput(tag);
  endtask

  task automatic writeReg(input logic [1:0] sel, input logic [7:0] data);
    applyStimulus(1'b0, 1'b1, sel, data, a12Level, "write");
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 1'b0, 2'd0, 8'd0, a12Level, "idle");
  endtask

  task automatic a12Pulse(input int lows, input int highs);
    a12Level = 1'b0;
    idle(lows);
    a12Level = 1'b1;
    idle(highs);
  endtask

  initial begin
    bit [7:0] expSeq [4];
    int runLeft;
    reset = 1'b1; reg_we = 1'b0; reg_sel = 2'd0; reg_data = 8'd0; ppu_a12 = 1'b0;
    a12Level = 1'b0;
    @(negedge m2);
    applyStimulus(1'b1, 1'b0, 2'd0, 8'd0, 1'b0, "reset");
    applyStimulus(1'b1, 1'b1, 2'd3, 8'd9, 1'b1, "resetPriority");
    check("resetCounter", counterNew, 8'd0);
    check("resetIrqN", {7'd0, irqNNew}, 8'd1);

    // Basic countdown: latch 3, four filtered rises -> 3,2,1,0 then IRQ.
    expSeq[0] = 8'd3; expSeq[1] = 8'd2; expSeq[2] = 8'd1; expSeq[3] = 8'd0;
    writeReg(2'd0, 8'd3);
    writeReg(2'd1, 8'd0);
    writeReg(2'd3, 8'd0);
    for (int i = 0; i < 4; i++) begin
      a12Pulse(5, 4);
      check("countdown", counterNew, expSeq[i]);
    end
    check("irqNewAfter4", {7'd0, irqNNew}, 8'd0);
    check("irqOldAfter4", {7'd0, irqNOld}, 8'd0);

    // Disable clears pending; re-enable without a new zero keeps IRQ off.
    writeReg(2'd2, 8'd0);
    check("disableIrq", {7'd0, irqNNew}, 8'd1);
    writeReg(2'd3, 8'd0);
    idle(3);
    check("reenableIrq", {7'd0, irqNNew}, 8'd1);

    // Short low gaps must not clock the counter.
    for (int i = 0; i < 6; i++) a12Pulse(2, 2);
    check("shortGapCounter", counterNew, 8'd0);
    check("shortGapIrq", {7'd0, irqNNew}, 8'd1);

    // Reload write landing on the same edge as a scanline clock.
    writeReg(2'd0, 8'd7);
    a12Level = 1'b0;
    idle(5);
    a12Level = 1'b1;
    idle(2);
    applyStimulus(1'b0, 1'b1, 2'd1, 8'd0, 1'b1, "reloadCoincident");
    check("reloadCoinCounter", counterNew, 8'd0);
    idle(1);
    a12Pulse(5, 4);
    check("reloadNextLoad", counterNew, 8'd7);

    // Zero latch: reload-forced zero fires both; plain zero fires only new mode.
    writeReg(2'd0, 8'd0);
    writeReg(2'd2, 8'd0);
    writeReg(2'd3, 8'd0);
    writeReg(2'd1, 8'd0);
    a12Pulse(5, 4);
    check("zeroReloadNew", {7'd0, irqNNew}, 8'd0);
    check("zeroReloadOld", {7'd0, irqNOld}, 8'd0);
    writeReg(2'd2, 8'd0);
    writeReg(2'd3, 8'd0);
    a12Pulse(5, 4);
    check("zeroPlainNew", {7'd0, irqNNew}, 8'd0);
    check("zeroPlainOld", {7'd0, irqNOld}, 8'd1);

    // Reset mid-count with pending set.
    writeReg(2'd0, 8'd5);
    a12Pulse(5, 4);
    check("preResetCounter", counterNew, 8'd5);
    check("preResetIrq", {7'd0, irqNNew}, 8'd0);
    applyStimulus(1'b1, 1'b0, 2'd0, 8'd0, 1'b1, "midReset");
    check("postResetCounter", counterNew, 8'd0);
    check("postResetIrq", {7'd0, irqNNew}, 8'd1);
    a12Pulse(5, 4);
    check("postResetDisabled", {7'd0, irqNNew}, 8'd1);

    // Randomized traffic against the model.
    runLeft = 0;
    for (int i = 0; i < 600; i++) begin
      if (runLeft == 0) begin
        a12Level = ~a12Level;
        runLeft = $urandom_range(1, 6);
      end
      runLeft--;
      applyStimulus(($urandom % 80) == 0, ($urandom % 4) == 0, 2'($urandom),
                    8'($urandom % 4), a12Level, "random");
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
